// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic operand feeder: default sizes,
// FSM encoding and the diagonal-skew index function.
package systolic_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  typedef struct packed {
    logic       vld;
    logic [7:0] idx;
  } skew_t;

  // Signed difference keeps k - lane from wrapping when lane > k.
  function automatic skew_t skew_idx(input int k, input int lane, input int n);
    skew_t r;
    int    d;
    d     = k - lane;
    r.vld = (d >= 0) && (d < n);
    r.idx = r.vld ? d[7:0] : 8'd0;
    return r;
  endfunction

endpackage

// File: rtl/operand_skew_buf.sv
// N x N operand store with a skewed edge read mux; TRANSPOSE selects
// row-wise (A, west edge) or column-wise (B, north edge) presentation.
module operand_skew_buf
  import systolic_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int DW        = DW_DEF,
  parameter bit TRANSPOSE = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic [$clog2(N)-1:0]      wr_row_i,
  input  logic [$clog2(N)-1:0]      wr_col_i,
  input  logic [DW-1:0]             wr_data_i,
  input  logic [$clog2(3*N):0]      step_i,
  output logic [N*DW-1:0]           edge_o
);

  logic [DW-1:0] mem_q [N][N];
  skew_t         sk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (wr_en_i) begin
      mem_q[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  // Lane l at step k carries element k-l of its row/column, or 0 outside the band.
  always_comb begin
    edge_o = '0;
    sk     = '0;
    for (int l = 0; l < N; l++) begin
      sk = skew_idx(int'(step_i), l, N);
      for (int c = 0; c < N; c++) begin
        if (sk.vld && (sk.idx == 8'(c))) begin
          edge_o[l*DW +: DW] = TRANSPOSE ? mem_q[c][l] : mem_q[l][c];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N systolic MAC grid: buffers A and B, clears the
// grid, then streams skewed, zero-padded rows/columns and flags completion.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [$clog2(N)-1:0] wr_row,
  input  logic [$clog2(N)-1:0] wr_col,
  input  logic [DW-1:0]        wr_data,
  input  logic                 start,
  output logic [N*DW-1:0]      a_edge,
  output logic [N*DW-1:0]      b_edge,
  output logic                 acc_clr,
  output logic                 busy,
  output logic                 done
);

  localparam int            SW     = $clog2(3*N) + 1;
  localparam logic [SW-1:0] T_LAST = SW'(3*N - 1);

  state_e          state_q;
  logic [SW-1:0]   t_q;
  logic [SW-1:0]   step_d;
  logic [N*DW-1:0] a_edge_q, b_edge_q;
  logic [N*DW-1:0] a_edge_d, b_edge_d;
  logic            acc_clr_q, busy_q, done_q;
  logic            buf_we;

  assign buf_we = wr_en && (state_q == ST_IDLE);

  // Edges are launched one step ahead so they are stable for the whole step.
  assign step_d = (state_q == ST_STREAM) ? t_q + 1'b1 : '0;

  operand_skew_buf #(.N(N), .DW(DW), .TRANSPOSE(1'b0)) u_buf_a (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (buf_we && !wr_sel),
    .wr_row_i  (wr_row),
    .wr_col_i  (wr_col),
    .wr_data_i (wr_data),
    .step_i    (step_d),
    .edge_o    (a_edge_d)
  );

  operand_skew_buf #(.N(N), .DW(DW), .TRANSPOSE(1'b1)) u_buf_b (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (buf_we && wr_sel),
    .wr_row_i  (wr_row),
    .wr_col_i  (wr_col),
    .wr_data_i (wr_data),
    .step_i    (step_d),
    .edge_o    (b_edge_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      a_edge_q  <= '0;
      b_edge_q  <= '0;
      acc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          a_edge_q  <= '0;
          b_edge_q  <= '0;
          done_q    <= 1'b0;
          t_q       <= '0;
          acc_clr_q <= start;
          busy_q    <= start;
          if (start) state_q <= ST_CLEAR;
        end
        ST_CLEAR: begin
          acc_clr_q <= 1'b0;
          t_q       <= '0;
          a_edge_q  <= a_edge_d;
          b_edge_q  <= b_edge_d;
          state_q   <= ST_STREAM;
        end
        ST_STREAM: begin
          if (t_q == T_LAST) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_edge_q <= '0;
            b_edge_q <= '0;
          end else begin
            t_q      <= step_d;
            a_edge_q <= a_edge_d;
            b_edge_q <= b_edge_d;
            done_q   <= (step_d == T_LAST);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a_edge  = a_edge_q;
  assign b_edge  = b_edge_q;
  assign acc_clr = acc_clr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural 4x4 MAC grid attached
// to the edges; expected edge words and products are hand-computed constants.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int T  = 3 * N;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic            wr_sel = 1'b0;
  logic [1:0]      wr_row = '0;
  logic [1:0]      wr_col = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            start = 1'b0;
  logic [N*DW-1:0] a_edge, b_edge;
  logic            acc_clr, busy, done;

  int total = 0;
  int bad   = 0;

  systolic_feeder #(.N(N), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .start   (start),
    .a_edge  (a_edge),
    .b_edge  (b_edge),
    .acc_clr (acc_clr),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Behavioural grid: a moves east, b moves south, each cell accumulates a*b.
  logic [DW-1:0] ga [N][N];
  logic [DW-1:0] gb [N][N];
  logic [63:0]   gc [N][N];
  logic [63:0]   snap [N][N];

  function automatic logic [DW-1:0] west_in(input int i, input int j);
    return (j == 0) ? a_edge[i*DW +: DW] : ga[i][(j == 0) ? 0 : j-1];
  endfunction

  function automatic logic [DW-1:0] north_in(input int i, input int j);
    return (i == 0) ? b_edge[j*DW +: DW] : gb[(i == 0) ? 0 : i-1][j];
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rst || acc_clr) begin
          ga[i][j] <= '0;
          gb[i][j] <= '0;
          gc[i][j] <= '0;
        end else begin
          ga[i][j] <= west_in(i, j);
          gb[i][j] <= north_in(i, j);
          gc[i][j] <= gc[i][j] + 64'(west_in(i, j)) * 64'(north_in(i, j));
        end
      end
    end
  end

  logic [N*DW-1:0] cap_a [T];
  logic [N*DW-1:0] cap_b [T];

  typedef struct {
    bit          is_b;
    int          lane;
    int          t;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [16];
  int   prod_exp [N][N];

  function automatic logic [DW-1:0] lane_of(input logic [N*DW-1:0] bus, input int l);
    return bus[l*DW +: DW];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input logic sel, input int r, input int c, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = 2'(r);
    wr_col  = 2'(c);
    wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  // Cycle c counts from the edge that samples start; t = k is cycle k + 2.
  task automatic do_run(input int inj_c, output int done_c, output int clr_cnt,
                        output logic clr_c1);
    done_c  = 0;
    clr_cnt = 0;
    clr_c1  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 30 && done_c == 0; c++) begin
      @(negedge clk);
      if (acc_clr) clr_cnt++;
      if (c == 1) clr_c1 = acc_clr;
      if (c >= 2 && c < T + 2) begin
        cap_a[c-2] = a_edge;
        cap_b[c-2] = b_edge;
      end
      if (done) begin
        done_c = c;
        snap   = gc;
      end
      if (inj_c != 0 && c == inj_c) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0;
        wr_row = 2'd0; wr_col = 2'd0; wr_data = 32'd99;
      end
      if (inj_c != 0 && c == inj_c + 1) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
    end
  endtask

  task automatic chk_prod(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), snap[i][j], 64'(prod_exp[i][j]));
  endtask

  initial begin
    int   dc, cc, nz;
    logic c1;

    tbl[0]  = '{1'b0, 2, 3, 32'd0};
    tbl[1]  = '{1'b0, 2, 4, 32'd1};
    tbl[2]  = '{1'b0, 2, 5, 32'd0};
    tbl[3]  = '{1'b0, 0, 0, 32'd1};
    tbl[4]  = '{1'b0, 0, 1, 32'd0};
    tbl[5]  = '{1'b0, 3, 6, 32'd1};
    tbl[6]  = '{1'b0, 1, 2, 32'd1};
    tbl[7]  = '{1'b1, 1, 0, 32'd0};
    tbl[8]  = '{1'b1, 1, 1, 32'd2};
    tbl[9]  = '{1'b1, 1, 2, 32'd6};
    tbl[10] = '{1'b1, 1, 3, 32'd10};
    tbl[11] = '{1'b1, 1, 4, 32'd14};
    tbl[12] = '{1'b1, 1, 5, 32'd0};
    tbl[13] = '{1'b1, 0, 0, 32'd1};
    tbl[14] = '{1'b1, 3, 3, 32'd4};
    tbl[15] = '{1'b1, 3, 6, 32'd16};
    prod_exp = '{'{10, 20, 30, 40}, '{16, 30, 44, 58},
                 '{22, 40, 58, 76}, '{28, 50, 72, 94}};

    repeat (3) @(negedge clk);
    chk("rst_a_edge", 64'(a_edge != '0), 64'd0);
    chk("rst_b_edge", 64'(b_edge != '0), 64'd0);
    chk("rst_acc_clr", 64'(acc_clr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Identity A, B[r][c] = 4r + c + 1
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r, c, (r == c) ? 32'd1 : 32'd0);
        wr(1'b1, r, c, 32'(4*r + c + 1));
      end
    do_run(0, dc, cc, c1);
    chk("id_done_cycle", 64'(dc), 64'd13);
    chk("id_acc_clr_cnt", 64'(cc), 64'd1);
    chk("id_acc_clr_c1", 64'(c1), 64'd1);
    for (int v = 0; v < 16; v++)
      chk($sformatf("id_%s%0d_t%0d", tbl[v].is_b ? "b" : "a", tbl[v].lane, tbl[v].t),
          64'(lane_of(tbl[v].is_b ? cap_b[tbl[v].t] : cap_a[tbl[v].t], tbl[v].lane)),
          64'(tbl[v].exp));
    nz = 0;
    for (int t = 0; t < T; t++) if (lane_of(cap_a[t], 2) != '0) nz++;
    chk("id_a2_nonzero_steps", 64'(nz), 64'd1);
    for (int t = 7; t < T; t++) begin
      chk($sformatf("drain_a_t%0d", t), 64'(cap_a[t] != '0), 64'd0);
      chk($sformatf("drain_b_t%0d", t), 64'(cap_b[t] != '0), 64'd0);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("id_c%0d%0d", i, j), snap[i][j], 64'(4*i + j + 1));
    @(negedge clk);
    chk("idle_a_edge", 64'(a_edge != '0), 64'd0);
    chk("idle_b_edge", 64'(b_edge != '0), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);

    // Full product: A[i][k] = i+k+1, B[k][j] = j-k+3
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r, c, 32'(r + c + 1));
        wr(1'b1, r, c, 32'(c - r + 3));
      end
    do_run(0, dc, cc, c1);
    chk("prod_done_cycle", 64'(dc), 64'd13);
    chk("prod_acc_clr_cnt", 64'(cc), 64'd1);
    chk("prod_acc_clr_c1", 64'(c1), 64'd1);
    chk_prod("prod");

    // start and a write to A[0][0] at t = 2 are both ignored
    do_run(4, dc, cc, c1);
    chk("busy_ign_done_cycle", 64'(dc), 64'd13);
    chk("busy_ign_acc_clr_cnt", 64'(cc), 64'd1);
    chk_prod("busy_ign");

    // Back-to-back: start in the first idle cycle after done
    do_run(0, dc, cc, c1);
    chk("b2b_done_cycle", 64'(dc), 64'd13);
    chk("b2b_acc_clr_c1", 64'(c1), 64'd1);
    chk("b2b_a00_kept", 64'(lane_of(cap_a[0], 0)), 64'd1);
    chk_prod("b2b");

    // Reset at t = 3 of a stream
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_pre", 64'(busy), 64'd1);
    chk("mid_a0_t3_pre", 64'(lane_of(a_edge, 0)), 64'd4);
    rst = 1'b1;
    #1;
    chk("mid_rst_a_edge", 64'(a_edge != '0), 64'd0);
    chk("mid_rst_b_edge", 64'(b_edge != '0), 64'd0);
    chk("mid_rst_acc_clr", 64'(acc_clr), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_run(0, dc, cc, c1);
    chk("post_rst_done_cycle", 64'(dc), 64'd13);
    nz = 0;
    for (int t = 0; t < T; t++) if (cap_a[t] != '0 || cap_b[t] != '0) nz++;
    chk("post_rst_nonzero_steps", 64'(nz), 64'd0);
    nz = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) if (snap[i][j] != '0) nz++;
    chk("post_rst_nonzero_cells", 64'(nz), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
